// File: rtl/poly_challenge_encode.sv
// Converts a dense challenge polynomial into sorted sparse positions plus sign bits and checks it is well-formed.
// One coefficient per cycle; done rises N edges after the accepting edge. start is level-held until done.
module poly_challenge_encode #(
  parameter int N   = 256,
  parameter int TAU = 49
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [N*32-1:0]   c_in,
  output logic [TAU*8-1:0]  pos_out,
  output logic [TAU-1:0]    signs_out,
  output logic [8:0]        weight,
  output logic              bad_coeff,
  output logic              valid,
  output logic              done
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state, state_nxt;
  logic [N*32-1:0] coef;
  logic [IW-1:0]   idx;
  logic [31:0]     cur;
  logic            is_pos, is_neg, is_bad, last;
  logic [8:0]      weight_nxt;
  logic            bad_nxt;

  // The latched copy shifts down each cycle, so the current coefficient is always the low word.
  assign cur = coef[31:0];

  always_comb begin
    state_nxt  = state;
    is_pos     = (cur == 32'h0000_0001);
    is_neg     = (cur == 32'hFFFF_FFFF);
    is_bad     = !is_pos && !is_neg && (cur != 32'h0);
    last       = (idx == IW'(N - 1));
    weight_nxt = weight + 9'(is_pos | is_neg);
    bad_nxt    = bad_coeff | is_bad;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last)  state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      coef      <= '0;
      idx       <= '0;
      pos_out   <= '0;
      signs_out <= '0;
      weight    <= '0;
      bad_coeff <= 1'b0;
      valid     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            coef      <= c_in;
            idx       <= '0;
            pos_out   <= '0;
            signs_out <= '0;
            weight    <= '0;
            bad_coeff <= 1'b0;
            valid     <= 1'b0;
          end
        end
        SCAN: begin
          coef      <= coef >> 32;
          idx       <= idx + IW'(1);
          bad_coeff <= bad_nxt;
          if (is_pos || is_neg) begin
            weight <= weight_nxt;
            // Nonzeros past TAU are counted but never stored.
            if (weight < 9'(TAU)) begin
              pos_out[int'(weight)*8 +: 8] <= 8'(idx);
              signs_out[int'(weight)]      <= is_neg;
            end
          end
          if (last) begin
            done  <= 1'b1;
            valid <= !bad_nxt && (weight_nxt == 9'(TAU));
          end
        end
        DONE: begin
          if (!start) done <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
